// File: rtl/pipeline_stall_controller_if.sv
// Hazard/stall control bundle between the pipeline datapath and its stall sequencer.
// The master modport is the datapath side; the slave modport is the controller side.
interface pipeline_stall_controller_if;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        halt_req;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        pipe_freeze;
  logic        halted;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  modport master (
    output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
           branch_taken, dmem_req, dmem_ready, halt_req,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           pipe_freeze, halted, mem_timeout, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
           branch_taken, dmem_req, dmem_ready, halt_req,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           pipe_freeze, halted, mem_timeout, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Prioritised hold/flush/bubble sequencer for the 5-stage pipeline (RUN/MEM_WAIT/DRAIN/HALTED).
// Define PERF_CNT_EN to build the saturating stall/flush cycle counters; otherwise they read 0.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT  = 15,
  parameter int DRAIN_CYCLES = 3
) (
  input logic clk,
  input logic reset,
  pipeline_stall_controller_if.slave ctl
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} stateT;

  stateT      stateReg, stateNext;
  logic [7:0] waitCntReg, waitCntNext;
  logic [2:0] drainCntReg, drainCntNext;
  logic       memTimeoutReg, memTimeoutNext;

  logic loadUse, memStall, evalRun;
  logic pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze;

  assign loadUse = ctl.id_ex_mem_read && (ctl.id_ex_rd != 5'd0) &&
                   ((ctl.id_ex_rd == ctl.if_id_rs1) || (ctl.id_ex_rd == ctl.if_id_rs2));
  assign memStall = ctl.dmem_req && !ctl.dmem_ready;

  always_comb begin
    stateNext      = stateReg;
    waitCntNext    = waitCntReg;
    drainCntNext   = drainCntReg;
    memTimeoutNext = memTimeoutReg;
    evalRun        = 1'b0;
    pcWrite        = 1'b1;
    ifIdWrite      = 1'b1;
    ifIdFlush      = 1'b0;
    idExBubble     = 1'b0;
    pipeFreeze     = 1'b0;

    case (stateReg)
      RUN: begin
        if (memStall) begin
          pipeFreeze  = 1'b1;
          stateNext   = MEM_WAIT;
          waitCntNext = 8'd1;
        end else begin
          evalRun = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!ctl.dmem_ready) begin
          pipeFreeze = 1'b1;
          if (waitCntReg == 8'(MEM_TIMEOUT)) begin
            memTimeoutNext = 1'b1;
            stateNext      = HALTED;
          end else begin
            waitCntNext = waitCntReg + 8'd1;
          end
        end else begin
          evalRun     = 1'b1;
          stateNext   = RUN;
          waitCntNext = 8'd0;
        end
      end
      DRAIN: begin
        // A pending memory access still freezes the back end; the drain count waits for it.
        if (memStall) begin
          pipeFreeze = 1'b1;
        end else begin
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
          if (drainCntReg == 3'(DRAIN_CYCLES)) begin
            stateNext = HALTED;
          end else begin
            drainCntNext = drainCntReg + 3'd1;
          end
        end
      end
      default: begin
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
      end
    endcase

    if (pipeFreeze || stateReg == DRAIN || stateReg == HALTED) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
    end

    // Normal issue priority: branch flush beats load-use, which beats halt acceptance.
    if (evalRun) begin
      if (ctl.branch_taken) begin
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
      end else if (loadUse) begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
      end else if (ctl.halt_req) begin
        pcWrite      = 1'b0;
        ifIdWrite    = 1'b0;
        ifIdFlush    = 1'b1;
        idExBubble   = 1'b1;
        stateNext    = DRAIN;
        drainCntNext = 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= RUN;
      waitCntReg    <= 8'd0;
      drainCntReg   <= 3'd0;
      memTimeoutReg <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      waitCntReg    <= waitCntNext;
      drainCntReg   <= drainCntNext;
      memTimeoutReg <= memTimeoutNext;
    end
  end

  assign ctl.pc_write     = pcWrite;
  assign ctl.if_id_write  = ifIdWrite;
  assign ctl.if_id_flush  = ifIdFlush;
  assign ctl.id_ex_bubble = idExBubble;
  assign ctl.pipe_freeze  = pipeFreeze;
  assign ctl.halted       = (stateReg == HALTED);
  assign ctl.mem_timeout  = memTimeoutReg;

`ifdef PERF_CNT_EN
  logic [31:0] stallCntReg, flushCntReg;
  logic        stallEvt, flushEvt;

  assign stallEvt = pipeFreeze || (evalRun && !ctl.branch_taken && loadUse);
  assign flushEvt = evalRun && ctl.branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (stallEvt && stallCntReg != 32'hFFFF_FFFF) stallCntReg <= stallCntReg + 32'd1;
      if (flushEvt && flushCntReg != 32'hFFFF_FFFF) flushCntReg <= flushCntReg + 32'd1;
    end
  end

  assign ctl.stall_cycles = stallCntReg;
  assign ctl.flush_cycles = flushCntReg;
`else
  assign ctl.stall_cycles = '0;
  assign ctl.flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: each driven cycle pushes its expected control vector and counter values;
// a negedge monitor pops and compares against the live DUT outputs.
module tb_pipeline_stall_controller;

  localparam int MEM_TIMEOUT  = 15;
  localparam int DRAIN_CYCLES = 3;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted, mem_timeout}; x = don't care
  localparam logic [6:0] IDLE = 7'b1100000;
  localparam logic [6:0] LUSE = 7'b0001000;
  localparam logic [6:0] FLSH = 7'b1111000;
  localparam logic [6:0] FRZ  = 7'b0000100;
  localparam logic [6:0] ACC  = 7'b0x11000;
  localparam logic [6:0] DRN  = 7'b0011000;
  localparam logic [6:0] HLT  = 7'b0011010;
  localparam logic [6:0] TOH  = 7'b0011011;

  typedef struct {
    string       tag;
    logic [6:0]  exp;
    logic [31:0] stall;
    logic [31:0] flush;
  } expT;

  logic clk;
  logic reset;
  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ctl  (bus)
  );

  expT   sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    stallExp = 0;
  int    flushExp = 0;
  string bitNames[7] = '{"mem_timeout", "halted", "pipe_freeze", "id_ex_bubble",
                         "if_id_flush", "if_id_write", "pc_write"};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit chk, input bit rst,
                      input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit br, input bit req, input bit rdy,
                      input bit hlt, input logic [6:0] exp, input int sInc, input int fInc);
    expT e;
    @(posedge clk);
    #1;
    reset              = rst;
    bus.id_ex_mem_read = mr;
    bus.id_ex_rd       = rd;
    bus.if_id_rs1      = rs1;
    bus.if_id_rs2      = rs2;
    bus.branch_taken   = br;
    bus.dmem_req       = req;
    bus.dmem_ready     = rdy;
    bus.halt_req       = hlt;
    if (chk) begin
      e.tag   = tag;
      e.exp   = exp;
      e.stall = PERF ? 32'(stallExp) : 32'd0;
      e.flush = PERF ? 32'(flushExp) : 32'd0;
      sbq.push_back(e);
    end
    stallExp += sInc;
    flushExp += fInc;
    if (rst) begin
      stallExp = 0;
      flushExp = 0;
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      expT        e;
      logic [6:0] got;
      int         errBefore;
      e = sbq.pop_front();
      errBefore = errors;
      got = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
             bus.pipe_freeze, bus.halted, bus.mem_timeout};
      for (int i = 0; i < 7; i++) begin
        if (e.exp[i] !== 1'bx) checkVal({e.tag, ".", bitNames[i]}, {31'd0, got[i]}, {31'd0, e.exp[i]});
      end
      checkVal({e.tag, ".stall_cycles"}, bus.stall_cycles, e.stall);
      checkVal({e.tag, ".flush_cycles"}, bus.flush_cycles, e.flush);
      $display("txn %-12s ctl=%b stall=%0d flush=%0d errs=%0d", e.tag, got,
               bus.stall_cycles, bus.flush_cycles, errors - errBefore);
    end
  end

  initial begin
    reset              = 1'b1;
    bus.id_ex_mem_read = 1'b0;
    bus.id_ex_rd       = 5'd0;
    bus.if_id_rs1      = 5'd0;
    bus.if_id_rs2      = 5'd0;
    bus.branch_taken   = 1'b0;
    bus.dmem_req       = 1'b0;
    bus.dmem_ready     = 1'b0;
    bus.halt_req       = 1'b0;

    //          tag          chk rst mr rd     rs1    rs2    br req rdy hlt exp  s  f
    step("rst",         0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
    step("idle",        1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
    step("lu_rs1",      1, 0, 1, 5'd2, 5'd2, 5'd4, 0, 0, 0, 0, LUSE, 1, 0);
    step("lu_release",  1, 0, 0, 5'd2, 5'd2, 5'd4, 0, 0, 0, 0, IDLE, 0, 0);
    step("x0_nohaz",    1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
    step("lu_rs2",      1, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, LUSE, 1, 0);
    step("lu_branch",   1, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, FLSH, 0, 1);
    step("idle2",       1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
    for (int k = 0; k < 4; k++)
      step("memwait",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, FRZ,  1, 0);
    step("mem_ready",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, IDLE, 0, 0);
    step("back_run",    1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
    step("halt_accept", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, ACC,  0, 0);
    step("drain1_br",   1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, DRN,  0, 0);
    step("drain_frz",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, FRZ,  1, 0);
    step("drain2",      1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, DRN,  0, 0);
    step("drain3",      1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, DRN,  0, 0);
    step("halted",      1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, HLT,  0, 0);
    step("halted_hold", 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, HLT,  0, 0);
    step("rst_halted",  1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, HLT,  0, 0);
    step("post_rst",    1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
    step("halt_acc2",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, ACC,  0, 0);
    step("drain_a",     1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, DRN,  0, 0);
    step("rst_drain",   1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, DRN,  0, 0);
    step("after_rst",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
    // Timeout: the RUN cycle that sees the stall plus MEM_TIMEOUT MEM_WAIT cycles are frozen.
    step("to_run",      1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, FRZ,  1, 0);
    for (int k = 0; k < MEM_TIMEOUT; k++)
      step("to_wait",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, FRZ,  1, 0);
    step("to_halted",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, TOH,  0, 0);
    step("to_sticky",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, TOH,  0, 0);
    step("tail",        0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);

    @(negedge clk);
    #1;
    checkVal("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
